// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared state encoding, field-width helpers and counter width
//            for the set-associative cache.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int CNT_W = 32;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_EVICT   = 3'd2;
    localparam logic [2:0] S_REFILL  = 3'd3;
    localparam logic [2:0] S_RESPOND = 3'd4;
    localparam logic [2:0] S_BYPASS  = 3'd5;

    // Byte-offset bits inside one line.
    function automatic int offset_bits(input int block_words);
        return $clog2(block_words * 4);
    endfunction

    // Set-index bits; the cache is assumed to have at least two sets.
    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Way-number width, kept at least one bit so a direct-mapped cache
    // still has a legal (constant zero) way field.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru.sv
`default_nettype none
// ============================================================================
// Module   : cache_lru
// Brief    : Per-set age-based LRU replacement. Accessed way gets age 0,
//            ways that were younger age by one; victim is the oldest way.
// Revision : 1.0 - initial release
// ============================================================================
module cache_lru
    import cache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int IDX_W = index_bits(SETS),
    parameter int WAY_W = way_bits(WAYS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] index,
    input  logic [WAY_W-1:0] way,
    input  logic             update,
    output logic [WAY_W-1:0] victim
);

    if (WAYS == 1) begin : g_direct
        logic unused_inputs;
        assign unused_inputs = ^{clk, reset, index, way, update};
        assign victim        = '0;
    end else begin : g_age
        logic [WAY_W-1:0] age [SETS][WAYS];
        logic [WAY_W-1:0] oldest;

        // Age update: accessed way becomes MRU, younger ways age (saturating).
        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        age[s][w] <= '0;
            end else if (update) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == way)
                        age[index][w] <= '0;
                    else if (age[index][w] <= age[index][way] &&
                             age[index][w] != WAY_W'(WAYS - 1))
                        age[index][w] <= age[index][w] + WAY_W'(1);
                end
            end
        end

        // Victim: oldest way of the addressed set, lowest index on a tie.
        always_comb begin
            victim = '0;
            oldest = age[index][0];
            for (int w = 1; w < WAYS; w++) begin
                if (age[index][w] > oldest) begin
                    oldest = age[index][w];
                    victim = WAY_W'(w);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_set_assoc.sv
`default_nettype none
// ============================================================================
// Module   : cache_set_assoc
// Brief    : Write-back, write-allocate set-associative cache between a
//            PicoRV32-style CPU port and a single-beat memory port, with an
//            uncached bypass above ADDR_LIMIT and hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_set_assoc
    import cache_pkg::*;
#(
    parameter int          BLOCK_WORDS = 2,
    parameter int          CACHE_KB    = 1,
    parameter int          WAYS        = 2,
    parameter logic [31:0] ADDR_LIMIT  = 32'h0000FFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid_pico,
    input  logic             mem_instr_pico,
    input  logic [31:0]      mem_addr_pico,
    input  logic [31:0]      mem_wdata_pico,
    input  logic [3:0]       mem_wstrb_pico,
    output logic             mem_ready_pico,
    output logic [31:0]      mem_rdata_pico,
    output logic             mem_valid_mem,
    output logic             mem_instr_mem,
    output logic [31:0]      mem_addr_mem,
    output logic [31:0]      mem_wdata_mem,
    output logic [3:0]       mem_wstrb_mem,
    input  logic             mem_ready_mem,
    input  logic [31:0]      mem_rdata_mem,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int SETS   = CACHE_KB * 1024 / (BLOCK_WORDS * 4 * WAYS);
    localparam int OFF_W  = offset_bits(BLOCK_WORDS);
    localparam int WORD_W = OFF_W - 2;
    localparam int IDX_W  = index_bits(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WAY_W  = way_bits(WAYS);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

    logic [31:0]      data_mem   [SETS][WAYS][BLOCK_WORDS];
    logic [TAG_W-1:0] tag_mem    [SETS][WAYS];
    logic [WAYS-1:0]  valid_bits [SETS];
    logic [WAYS-1:0]  dirty_bits [SETS];

    logic [2:0]        state;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              req_instr;
    logic              bypass;
    logic [31:0]       bypass_data;
    logic [WAY_W-1:0]  way;
    logic [WORD_W-1:0] word_cnt;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_word;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              have_invalid;
    logic [WAY_W-1:0]  invalid_way;
    logic [WAY_W-1:0]  lru_victim;
    logic [WAY_W-1:0]  victim;
    logic              beat_done;
    logic              lru_update;
    logic [WAY_W-1:0]  lru_way;

    assign req_idx   = req_addr[OFF_W +: IDX_W];
    assign req_tag   = req_addr[31 -: TAG_W];
    assign req_word  = req_addr[2 +: WORD_W];
    assign beat_done = mem_valid_mem && mem_ready_mem;
    assign victim    = have_invalid ? invalid_way : lru_victim;

    // Parallel tag compare and first-invalid-way search for the latched set.
    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        have_invalid = 1'b0;
        invalid_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_bits[req_idx][w] && tag_mem[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!have_invalid && !valid_bits[req_idx][w]) begin
                have_invalid = 1'b1;
                invalid_way  = WAY_W'(w);
            end
        end
    end

    assign lru_update = (state == S_LOOKUP && hit) ||
                        (state == S_REFILL && beat_done && word_cnt == LAST_WORD);
    assign lru_way    = (state == S_LOOKUP) ? hit_way : way;

    cache_lru #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_lru (
        .clk    (clk),
        .reset  (reset),
        .index  (req_idx),
        .way    (lru_way),
        .update (lru_update),
        .victim (lru_victim)
    );

    assign mem_ready_pico = (state == S_RESPOND);
    assign mem_rdata_pico = (state != S_RESPOND) ? 32'h0 :
                            bypass ? bypass_data : data_mem[req_idx][way][req_word];

    // Control FSM, line metadata, memory beat sequencing and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            req_addr      <= '0;
            req_wdata     <= '0;
            req_wstrb     <= '0;
            req_instr     <= 1'b0;
            bypass        <= 1'b0;
            bypass_data   <= '0;
            way           <= '0;
            word_cnt      <= '0;
            mem_valid_mem <= 1'b0;
            mem_instr_mem <= 1'b0;
            mem_addr_mem  <= '0;
            mem_wdata_mem <= '0;
            mem_wstrb_mem <= '0;
            hit_count     <= '0;
            miss_count    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_bits[s] <= '0;
                dirty_bits[s] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_valid_pico) begin
                        req_addr  <= mem_addr_pico;
                        req_wdata <= mem_wdata_pico;
                        req_wstrb <= mem_wstrb_pico;
                        req_instr <= mem_instr_pico;
                        bypass    <= (mem_addr_pico > ADDR_LIMIT);
                        state     <= (mem_addr_pico > ADDR_LIMIT) ? S_BYPASS : S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                        way   <= hit_way;
                        state <= S_RESPOND;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                        way      <= victim;
                        word_cnt <= '0;
                        state    <= (valid_bits[req_idx][victim] && dirty_bits[req_idx][victim])
                                    ? S_EVICT : S_REFILL;
                    end
                end
                S_EVICT: begin
                    if (!mem_valid_mem) begin
                        mem_valid_mem <= 1'b1;
                        mem_instr_mem <= 1'b0;
                        mem_addr_mem  <= {tag_mem[req_idx][way], req_idx, word_cnt, 2'b00};
                        mem_wdata_mem <= data_mem[req_idx][way][word_cnt];
                        mem_wstrb_mem <= 4'hF;
                    end else if (mem_ready_mem) begin
                        mem_valid_mem <= 1'b0;
                        if (word_cnt == LAST_WORD) begin
                            dirty_bits[req_idx][way] <= 1'b0;
                            word_cnt                 <= '0;
                            state                    <= S_REFILL;
                        end else begin
                            word_cnt <= word_cnt + WORD_W'(1);
                        end
                    end
                end
                S_REFILL: begin
                    if (!mem_valid_mem) begin
                        mem_valid_mem <= 1'b1;
                        mem_instr_mem <= req_instr;
                        mem_addr_mem  <= {req_tag, req_idx, word_cnt, 2'b00};
                        mem_wdata_mem <= '0;
                        mem_wstrb_mem <= 4'h0;
                    end else if (mem_ready_mem) begin
                        mem_valid_mem <= 1'b0;
                        if (word_cnt == LAST_WORD) begin
                            valid_bits[req_idx][way] <= 1'b1;
                            dirty_bits[req_idx][way] <= 1'b0;
                            tag_mem[req_idx][way]    <= req_tag;
                            state                    <= S_RESPOND;
                        end else begin
                            word_cnt <= word_cnt + WORD_W'(1);
                        end
                    end
                end
                S_BYPASS: begin
                    if (!mem_valid_mem) begin
                        mem_valid_mem <= 1'b1;
                        mem_instr_mem <= req_instr;
                        mem_addr_mem  <= req_addr;
                        mem_wdata_mem <= req_wdata;
                        mem_wstrb_mem <= req_wstrb;
                    end else if (mem_ready_mem) begin
                        mem_valid_mem <= 1'b0;
                        bypass_data   <= mem_rdata_mem;
                        state         <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (!bypass && req_wstrb != 4'h0)
                        dirty_bits[req_idx][way] <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Data array: refill beats land word by word; CPU writes merge per byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == S_REFILL && beat_done) begin
                data_mem[req_idx][way][word_cnt] <= mem_rdata_mem;
            end else if (state == S_RESPOND && !bypass) begin
                for (int b = 0; b < 4; b++)
                    if (req_wstrb[b])
                        data_mem[req_idx][way][req_word][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_set_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_set_assoc
// Brief    : Directed self-checking bench: expected CPU responses queued by
//            the driver, compared by a monitor; memory model logs beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_set_assoc;

    logic        clk;
    logic        reset;
    logic        mem_valid_pico, mem_instr_pico;
    logic [31:0] mem_addr_pico, mem_wdata_pico;
    logic [3:0]  mem_wstrb_pico;
    logic        mem_ready_pico;
    logic [31:0] mem_rdata_pico;
    logic        mem_valid_mem, mem_instr_mem;
    logic [31:0] mem_addr_mem, mem_wdata_mem;
    logic [3:0]  mem_wstrb_mem;
    logic        mem_ready_mem;
    logic [31:0] mem_rdata_mem;
    logic [31:0] hit_count, miss_count;

    cache_set_assoc dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid_pico (mem_valid_pico),
        .mem_instr_pico (mem_instr_pico),
        .mem_addr_pico  (mem_addr_pico),
        .mem_wdata_pico (mem_wdata_pico),
        .mem_wstrb_pico (mem_wstrb_pico),
        .mem_ready_pico (mem_ready_pico),
        .mem_rdata_pico (mem_rdata_pico),
        .mem_valid_mem  (mem_valid_mem),
        .mem_instr_mem  (mem_instr_mem),
        .mem_addr_mem   (mem_addr_mem),
        .mem_wdata_mem  (mem_wdata_mem),
        .mem_wstrb_mem  (mem_wstrb_mem),
        .mem_ready_mem  (mem_ready_mem),
        .mem_rdata_mem  (mem_rdata_mem),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } beat_t;

    exp_t        exp_q [$];
    beat_t       log_q [$];
    logic [31:0] mem_model [logic [31:0]];

    int          checks = 0;
    int          errors = 0;
    int          stall_cycles = 0;
    logic [31:0] block_addr = 32'hFFFF_FFFF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : (32'h5A00_0000 | a);
    endfunction

    // Memory responder: one beat at a time, optional stall, stability check.
    initial begin : responder
        int          wait_cnt;
        logic [31:0] hold_a, hold_d, cur;
        wait_cnt      = 0;
        hold_a        = '0;
        hold_d        = '0;
        mem_ready_mem = 1'b0;
        mem_rdata_mem = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_ready_mem) begin
                mem_ready_mem = 1'b0;
                wait_cnt      = 0;
            end else if (mem_valid_mem && mem_addr_mem != block_addr) begin
                if (wait_cnt == 0) begin
                    hold_a = mem_addr_mem;
                    hold_d = mem_wdata_mem;
                end else begin
                    chk("beat_addr_stable", mem_addr_mem, hold_a);
                    chk("beat_wdata_stable", mem_wdata_mem, hold_d);
                end
                if (wait_cnt >= stall_cycles) begin
                    cur = mem_rd(mem_addr_mem);
                    mem_rdata_mem = cur;
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb_mem[b]) cur[8*b +: 8] = mem_wdata_mem[8*b +: 8];
                    if (mem_wstrb_mem != 4'h0) mem_model[mem_addr_mem] = cur;
                    log_q.push_back('{mem_addr_mem, mem_wdata_mem, mem_wstrb_mem, mem_instr_mem});
                    mem_ready_mem = 1'b1;
                    wait_cnt      = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Response monitor: pop the expectation whenever the CPU port completes.
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset && mem_ready_pico) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual=1 required=0");
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) chk("cpu_rdata", mem_rdata_pico, mon_e.data);
            end
        end
    end

    // Issue one CPU request (called #1 after a posedge); lat = edges to ready.
    task automatic cpu_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input logic instr, input logic [31:0] exp_d, output int lat);
        logic done;
        exp_q.push_back('{(ws == 4'h0), exp_d});
        mem_valid_pico = 1'b1;
        mem_instr_pico = instr;
        mem_addr_pico  = a;
        mem_wdata_pico = wd;
        mem_wstrb_pico = ws;
        lat  = 0;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            lat++;
            if (mem_ready_pico) begin
                done = 1'b1;
                break;
            end
        end
        mem_valid_pico = 1'b0;
        chk("cpu_req_completes", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_beat(input string name, input int i, input logic [31:0] a,
                            input logic [3:0] ws, input logic instr);
        if (i >= log_q.size()) begin
            chk(name, 32'hFFFF_FFFF, a);
        end else begin
            chk(name, log_q[i].addr, a);
            chk({name, "_wstrb"}, {28'd0, log_q[i].wstrb}, {28'd0, ws});
            chk({name, "_instr"}, {31'd0, log_q[i].instr}, {31'd0, instr});
        end
    endtask

    initial begin : stimulus
        int   lat;
        logic found;
        reset          = 1'b0;
        mem_valid_pico = 1'b0;
        mem_instr_pico = 1'b0;
        mem_addr_pico  = '0;
        mem_wdata_pico = '0;
        mem_wstrb_pico = '0;
        mem_model[32'h0000_0000] = 32'h1000_0000;
        mem_model[32'h0000_0004] = 32'h1122_3344;
        mem_model[32'h0001_0000] = 32'hBEEF_0001;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid_mem", {31'd0, mem_valid_mem}, 32'd0);
        chk("rst_ready_pico", {31'd0, mem_ready_pico}, 32'd0);
        chk("rst_addr_mem", mem_addr_mem, 32'd0);
        chk("rst_rdata_pico", mem_rdata_pico, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Cold read then re-read of 0x0000.
        cpu_req(32'h0000_0000, 32'h0, 4'h0, 1'b0, 32'h1000_0000, lat);
        chk("cold_misses", miss_count, 32'd1);
        chk("cold_hits", hit_count, 32'd0);
        chk("cold_beats", log_q.size(), 32'd2);
        chk_beat("cold_beat0", 0, 32'h0000_0000, 4'h0, 1'b0);
        chk_beat("cold_beat1", 1, 32'h0000_0004, 4'h0, 1'b0);
        log_q.delete();
        cpu_req(32'h0000_0000, 32'h0, 4'h0, 1'b0, 32'h1000_0000, lat);
        chk("hit_latency", lat, 32'd2);
        chk("hit_hits", hit_count, 32'd1);
        chk("hit_beats", log_q.size(), 32'd0);

        // Partial write hit merges into fetched data.
        cpu_req(32'h0000_0004, 32'hAABB_CCDD, 4'b0011, 1'b0, 32'h0, lat);
        cpu_req(32'h0000_0004, 32'h0, 4'h0, 1'b0, 32'h1122_CCDD, lat);
        chk("merge_hits", hit_count, 32'd3);
        chk("merge_beats", log_q.size(), 32'd0);

        // Fill the other way, then force eviction of the dirty LRU line.
        cpu_req(32'h0000_0200, 32'h0, 4'h0, 1'b0, 32'h5A00_0200, lat);
        chk("way1_beats", log_q.size(), 32'd2);
        log_q.delete();
        cpu_req(32'h0000_0400, 32'h0, 4'h0, 1'b0, 32'h5A00_0400, lat);
        chk("evict_beats", log_q.size(), 32'd4);
        chk_beat("evict_w0", 0, 32'h0000_0000, 4'hF, 1'b0);
        chk_beat("evict_w1", 1, 32'h0000_0004, 4'hF, 1'b0);
        chk_beat("evict_r0", 2, 32'h0000_0400, 4'h0, 1'b0);
        chk_beat("evict_r1", 3, 32'h0000_0404, 4'h0, 1'b0);
        if (log_q.size() >= 2) begin
            chk("evict_wdata0", log_q[0].wdata, 32'h1000_0000);
            chk("evict_wdata1", log_q[1].wdata, 32'h1122_CCDD);
        end
        chk("evict_mem_wb", mem_rd(32'h0000_0004), 32'h1122_CCDD);
        chk("evict_misses", miss_count, 32'd3);
        log_q.delete();
        cpu_req(32'h0000_0204, 32'h0, 4'h0, 1'b0, 32'h5A00_0204, lat);
        chk("resident_hits", hit_count, 32'd4);
        chk("resident_beats", log_q.size(), 32'd0);

        // Uncached bypass above ADDR_LIMIT.
        cpu_req(32'h0001_0000, 32'h0, 4'h0, 1'b1, 32'hBEEF_0001, lat);
        chk("byp_beats", log_q.size(), 32'd1);
        chk_beat("byp_beat", 0, 32'h0001_0000, 4'h0, 1'b1);
        chk("byp_hits", hit_count, 32'd4);
        chk("byp_misses", miss_count, 32'd3);
        log_q.delete();

        // Stalled memory: 20 cycles per beat, instruction refill.
        stall_cycles = 20;
        cpu_req(32'h0000_0608, 32'h0, 4'h0, 1'b1, 32'h5A00_0608, lat);
        stall_cycles = 0;
        chk("stall_beats", log_q.size(), 32'd2);
        chk_beat("stall_r0", 0, 32'h0000_0608, 4'h0, 1'b1);
        chk_beat("stall_r1", 1, 32'h0000_060C, 4'h0, 1'b1);
        chk("stall_misses", miss_count, 32'd4);
        log_q.delete();

        // Reset while the second refill beat is outstanding.
        block_addr     = 32'h0000_080C;
        mem_valid_pico = 1'b1;
        mem_instr_pico = 1'b0;
        mem_addr_pico  = 32'h0000_0808;
        mem_wstrb_pico = 4'h0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (mem_valid_mem && mem_addr_mem == 32'h0000_080C) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_beat_seen", {31'd0, found}, 32'd1);
        reset          = 1'b0;
        mem_valid_pico = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid_mem", {31'd0, mem_valid_mem}, 32'd0);
        chk("midrst_ready_pico", {31'd0, mem_ready_pico}, 32'd0);
        chk("midrst_misses", miss_count, 32'd0);
        reset      = 1'b1;
        block_addr = 32'hFFFF_FFFF;
        log_q.delete();
        @(posedge clk); #1;
        cpu_req(32'h0000_0808, 32'h0, 4'h0, 1'b0, 32'h5A00_0808, lat);
        chk("post_rst_misses", miss_count, 32'd1);
        chk("post_rst_hits", hit_count, 32'd0);
        chk("post_rst_beats", log_q.size(), 32'd2);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_set_assoc.md
CACHE_SET_ASSOC -- requirements
Module: cache_set_assoc

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 2, meaning 32-bit words per line (power of 2, >=2).
REQ-002 SHALL have parameter CACHE_KB, default 1, meaning total data capacity in KiB.
REQ-003 SHALL have parameter WAYS, default 2, meaning associativity (power of 2, 1..8); SETS = CACHE_KB*1024/(BLOCK_WORDS*4*WAYS).
REQ-004 SHALL have parameter ADDR_LIMIT, default 32'h0000FFFF, meaning the highest cacheable byte address.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 mem_valid_pico / mem_instr_pico  in  1 / 1  CPU request valid / instruction fetch.
REQ-008 mem_addr_pico / mem_wdata_pico / mem_wstrb_pico  in  32 / 32 / 4  CPU address, write data, byte strobes (0 = read).
REQ-009 mem_ready_pico / mem_rdata_pico  out  1 / 32  CPU completion pulse, read data.
REQ-010 mem_valid_mem / mem_instr_mem / mem_addr_mem / mem_wdata_mem / mem_wstrb_mem  out  1/1/32/32/4  main-memory request.
REQ-011 mem_ready_mem / mem_rdata_mem  in  1 / 32  main-memory completion, read data.
REQ-012 hit_count / miss_count  out  32 / 32  saturating performance counters.

Function
REQ-013 Address split: offset = log2(BLOCK_WORDS*4) LSBs, index = log2(SETS) bits above it, tag = remaining MSBs.
REQ-014 FSM states: IDLE, LOOKUP, EVICT, REFILL, RESPOND, BYPASS.
REQ-015 IDLE: on mem_valid_pico, latch addr/wdata/wstrb/instr; go to BYPASS if addr > ADDR_LIMIT, else to LOOKUP.
REQ-016 LOOKUP: compare all WAYS tags in parallel; a hit on a valid way increments hit_count and goes to RESPOND.
REQ-017 Miss: increment miss_count; victim = first invalid way (lowest index), else the LRU way; go to EVICT if the victim is dirty, else to REFILL.
REQ-018 EVICT: write BLOCK_WORDS words to {victim tag, index, word offset}, ascending, wstrb 4'hF; then clear dirty and go to REFILL.
REQ-019 REFILL: read BLOCK_WORDS words from the line base, ascending; after the last word set valid and the new tag, then go to RESPOND.
REQ-020 Memory beat: mem_valid_mem stays high until the cycle mem_ready_mem is sampled high, deasserts next cycle; addr/wdata stable throughout; at most one beat outstanding.
REQ-021 RESPOND: a read drives the addressed word; a write merges only the bytes enabled in wstrb and sets dirty; mem_ready_pico is high for exactly one cycle; return to IDLE.
REQ-022 No new request is accepted in the cycle mem_ready_pico is high.
REQ-023 Hit latency: mem_ready_pico rises 2 cycles after the IDLE cycle that samples the request.
REQ-024 LRU update on every hit and every fill: the accessed way becomes MRU; with WAYS=1 the replacement logic is absent.
REQ-025 BYPASS: forward the request unchanged as one memory beat; return mem_rdata_mem with a one-cycle mem_ready_pico; no cache state or counter changes.
REQ-026 Write miss is write-allocate: refill, then merge in RESPOND.
REQ-027 Counters saturate at 32'hFFFFFFFF; a simultaneous hit and miss is impossible.
REQ-028 mem_instr_mem = latched mem_instr_pico on refill/bypass beats, 0 on evict beats.

Reset
REQ-029 While reset=0 at a clk edge: all valid, dirty and LRU bits cleared; counters 0; state IDLE.
REQ-030 Reset outputs: mem_ready_pico, mem_valid_mem, mem_instr_mem 0; mem_addr_mem, mem_wdata_mem, mem_rdata_pico 0; mem_wstrb_mem 0.
REQ-031 Reset mid-EVICT/REFILL abandons the beat within one cycle (mem_valid_mem=0 next cycle); no partial line is marked valid.

Structure
REQ-032 A shared package cache_pkg SHALL hold the state encoding, the field-width derivation functions and the counter width.
REQ-033 Replacement SHALL be a sub-module cache_lru (per-set age state, inputs index/way/update, output victim way).
REQ-034 Data array SHALL be SETS x WAYS x BLOCK_WORDS words, with tag/valid/dirty in a separate array.

Verification (WAYS=2, BLOCK_WORDS=2, CACHE_KB=1; set stride 0x200)
REQ-035 Read 0x0000 cold, then again -> first: miss_count=1 plus 2 memory reads (0x0, 0x4); second: hit_count=1, ready 2 cycles after request, no memory traffic.
REQ-036 Write 0x0004 wdata 0xAABBCCDD, wstrb 4'b0011, over memory 0x11223344 -> a read of 0x0004 returns 0x1122CCDD.
REQ-037 Dirty 0x0000, read 0x0200, then read 0x0400 -> line 0x0000 evicted (writes 0x0/0x4 precede refill reads 0x400/0x404); 0x0200 stays resident.
REQ-038 Read 0x10000 -> exactly one memory beat at 0x10000 passed through; counters unchanged.
REQ-039 Assert reset during the second refill beat -> mem_valid_mem=0 next cycle; a later read of the same address misses.
REQ-040 Hold mem_ready_mem low 20 cycles during a beat -> mem_valid_mem and mem_addr_mem held stable; completes correctly.
